// File: rtl/portin_pkg.sv
// Shared types and defaults for the 1-bit port-link receiver.
package portin_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    IDLE  = 2'd1,
    RECV  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/portin.sv
// Serial-to-parallel receiver: rebuilds LSB-first WIDTH-bit words from the
// frame_n/valid_n/din link and strobes them into the ingress FIFO.
module portin
  import portin_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frame_n,
  input  logic             valid_n,
  input  logic             din,
  input  logic             full,
  output logic [WIDTH-1:0] payload,
  output logic             push,
  output logic             err_short,
  output logic             err_long,
  output logic             drop,
  output logic [CNT_W-1:0] frames_ok
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] payload_q, payload_d;
  logic             push_q, push_d;
  logic             err_short_q, err_short_d;
  logic             err_long_q, err_long_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] frames_ok_q, frames_ok_d;

  // push is a write strobe with no ready: the FIFO reports full, and a good
  // frame ending while full is discarded (drop) instead of stalling the link.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    payload_d   = payload_q;
    frames_ok_d = frames_ok_q;
    push_d      = 1'b0;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    drop_d      = 1'b0;
    unique case (state_q)
      SYNC: begin
        if (frame_n) state_d = IDLE;
      end
      IDLE: begin
        if (!frame_n) begin
          state_d = RECV;
          shift_d = '0;
          cnt_d   = '0;
          if (!valid_n) begin
            shift_d = WIDTH'(din);
            cnt_d   = CW'(1);
          end
        end
      end
      RECV: begin
        if (frame_n) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (cnt_q == CNT_FULL) begin
            if (full) begin
              drop_d = 1'b1;
            end else begin
              push_d      = 1'b1;
              payload_d   = shift_q;
              frames_ok_d = frames_ok_q + 1'b1;
            end
          end else begin
            err_short_d = 1'b1;
          end
        end else if (!valid_n) begin
          if (cnt_q == CNT_FULL) begin
            err_long_d = 1'b1;
            state_d    = DRAIN;
            cnt_d      = '0;
          end else begin
            // shift is cleared at frame start, so OR-ing places the bit at cnt
            shift_d = shift_q | (WIDTH'(din) << cnt_q);
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (frame_n) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= SYNC;
      cnt_q       <= '0;
      shift_q     <= '0;
      payload_q   <= '0;
      push_q      <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      drop_q      <= 1'b0;
      frames_ok_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      payload_q   <= payload_d;
      push_q      <= push_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      drop_q      <= drop_d;
      frames_ok_q <= frames_ok_d;
    end
  end

  assign payload   = payload_q;
  assign push      = push_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign drop      = drop_q;
  assign frames_ok = frames_ok_q;

endmodule

// File: tb/tb_portin.sv
// Directed bench for portin: builds link frames bit by bit and checks the
// end-of-frame pulses, payload and frame counter against hand-derived values.
module tb_portin;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 16;

  logic             clock;
  logic             reset;
  logic             frame_n;
  logic             valid_n;
  logic             din;
  logic             full;
  logic [WIDTH-1:0] payload;
  logic             push;
  logic             err_short;
  logic             err_long;
  logic             drop;
  logic [CNT_W-1:0] frames_ok;

  int n_cmp  = 0;
  int n_fail = 0;

  int n_push = 0, n_short = 0, n_long = 0, n_drop = 0;
  int e_push = 0, e_short = 0, e_long = 0, e_drop = 0;
  int exp_frames = 0;

  portin #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .frame_n   (frame_n),
    .valid_n   (valid_n),
    .din       (din),
    .full      (full),
    .payload   (payload),
    .push      (push),
    .err_short (err_short),
    .err_long  (err_long),
    .drop      (drop),
    .frames_ok (frames_ok)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // pulse tallies, sampled mid-cycle
  always @(negedge clock) begin
    if (push)      n_push++;
    if (err_short) n_short++;
    if (err_long)  n_long++;
    if (drop)      n_drop++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tallies(input string tag);
    chk({tag, " push count"},  64'(n_push),  64'(e_push));
    chk({tag, " short count"}, 64'(n_short), 64'(e_short));
    chk({tag, " long count"},  64'(n_long),  64'(e_long));
    chk({tag, " drop count"},  64'(n_drop),  64'(e_drop));
    chk({tag, " frames_ok"},   64'(frames_ok), 64'(exp_frames[CNT_W-1:0]));
  endtask

  // kind: 0 = expect push, 1 = expect err_short, 2 = expect drop
  task automatic send_frame(input string tag, input logic [63:0] data, input int nbits,
                            input logic [63:0] gaps, input logic full_end, input int kind);
    for (int i = 0; i < nbits; i++) begin
      if (gaps[i]) begin
        frame_n = 1'b0; valid_n = 1'b1;
        repeat (3) begin
          din = 1'($urandom_range(0, 1));
          tick();
        end
      end
      frame_n = 1'b0; valid_n = 1'b0; din = data[i];
      full = 1'($urandom_range(0, 1));
      tick();
      chk({tag, " no pulse mid-frame"}, 64'({push, err_short, err_long, drop}), 64'd0);
    end
    frame_n = 1'b1; valid_n = 1'($urandom_range(0, 1)); din = 1'($urandom_range(0, 1));
    full = full_end;
    tick();
    chk({tag, " push"},      64'(push),      64'(kind == 0));
    chk({tag, " err_short"}, 64'(err_short), 64'(kind == 1));
    chk({tag, " drop"},      64'(drop),      64'(kind == 2));
    chk({tag, " err_long"},  64'(err_long),  64'd0);
    if (kind == 0) begin
      chk({tag, " payload"}, 64'(payload), 64'(data[WIDTH-1:0]));
      e_push++;
      exp_frames++;
    end else if (kind == 1) begin
      e_short++;
    end else begin
      e_drop++;
    end
    full = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame_n = 1'b0; valid_n = 1'b0; din = 1'b0; full = 1'b0;

    // 1: reset with frame_n low; SYNC must not lock onto the running frame
    repeat (2) tick();
    chk("reset payload",   64'(payload),   64'd0);
    chk("reset frames_ok", 64'(frames_ok), 64'd0);
    chk("reset pulses",    64'({push, err_short, err_long, drop}), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      din = 1'($urandom_range(0, 1));
      tick();
    end
    frame_n = 1'b1; valid_n = 1'b1;
    tick();
    tick();
    chk_tallies("sync");

    // 2: plain frame
    send_frame("frame1", 64'hA5A5_1234, 32, 64'd0, 1'b0, 0);
    tick();
    chk("frame1 push falls", 64'(push), 64'd0);
    chk("frame1 payload holds", 64'(payload), 64'hA5A5_1234);
    chk_tallies("frame1");

    // 3: stalls before bits 5 and 17, then a back-to-back frame after a 1-cycle gap
    send_frame("gaps", 64'hA5A5_1234, 32, (64'd1 << 5) | (64'd1 << 17), 1'b0, 0);
    send_frame("b2b", 64'h0000_0001, 32, 64'd0, 1'b0, 0);
    tick();
    chk_tallies("gaps");

    // 4: short frame, zero-bit frame, long frame
    send_frame("short20", 64'h000F_FFFF, 20, 64'd0, 1'b0, 1);
    frame_n = 1'b0; valid_n = 1'b1;
    repeat (2) tick();
    frame_n = 1'b1;
    tick();
    chk("zero-bit err_short", 64'(err_short), 64'd1);
    e_short++;
    tick();
    for (int i = 0; i < 33; i++) begin
      frame_n = 1'b0; valid_n = 1'b0; din = 1'(i % 3 == 0);
      tick();
    end
    chk("long err_long", 64'(err_long), 64'd1);
    e_long++;
    for (int i = 0; i < 4; i++) begin
      din = 1'($urandom_range(0, 1));
      tick();
    end
    chk("drain quiet", 64'({push, err_short, err_long, drop}), 64'd0);
    frame_n = 1'b1; valid_n = 1'b1;
    tick();
    chk("drain exit quiet", 64'({push, err_short, err_long, drop}), 64'd0);
    tick();
    chk_tallies("errors");

    // 5: full at frame end drops, next frame pushes
    send_frame("full", 64'h1234_5678, 32, 64'd0, 1'b1, 2);
    chk("full payload holds", 64'(payload), 64'h0000_0001);
    send_frame("after_full", 64'h0F0F_C3C3, 32, 64'd0, 1'b0, 0);
    tick();
    chk_tallies("full");

    // 6: reset at bit 10 of a frame
    for (int i = 0; i < 10; i++) begin
      frame_n = 1'b0; valid_n = 1'b0; din = 1'($urandom_range(0, 1));
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_frames = 0;
    chk("midreset payload", 64'(payload), 64'd0);
    chk("midreset pulses",  64'({push, err_short, err_long, drop}), 64'd0);
    for (int i = 11; i < 32; i++) begin
      din = 1'($urandom_range(0, 1));
      tick();
    end
    frame_n = 1'b1; valid_n = 1'b1;
    tick();
    chk("midreset end quiet", 64'({push, err_short, err_long, drop}), 64'd0);
    send_frame("clean", 64'hDEAD_BEEF, 32, 64'd0, 1'b0, 0);
    tick();
    chk_tallies("midreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
